aes_key_sched_ctrl: RTL
=======================

// Module: aes_key_sched_ctrl
// PURPOSE
//   Sequences the byte-serial key-expansion unit through all AES-128 rounds. Loads the cipher key,
//   feeds the previous round key plus RCON to the expander and captures each expanded round key.
//   Serves stored round keys to the cipher core on request. Sits between the key input stream,
//   the key-expansion unit and the round datapath.
// PARAMETERS
//   NUM_ROUNDS   10    expansion rounds (round keys 0..NUM_ROUNDS stored)
//   KEY_BYTES    16    bytes per round key
//   TIMEOUT      255   watchdog limit in cycles (used only with KEY_SCHED_TIMEOUT_EN)
// PORTS
//   clk          in   1  clock, all state on rising edge
//   rst_n        in   1  asynchronous active-low reset
//   start        in   1  begin a new key schedule
//   key_valid    in   1  key_byte qualifier
//   key_byte     in   8  cipher key, FIPS-197 byte order 0..15
//   ke_start     out  1  one-cycle pulse: expander begins a round
//   ke_rcon      out  8  round constant, stable through FEED and WAIT
//   ke_key_valid out  1  ke_key_byte qualifier
//   ke_key_byte  out  8  previous round key to expander, bytes 0..15
//   ke_out_valid in   1  ke_out_byte qualifier
//   ke_out_byte  in   8  expanded round-key byte, bytes 0..15 in order
//   rk_req       in   1  cipher requests a round key
//   rk_round     in   4  requested round index
//   rk_valid     out  1  rk_byte qualifier
//   rk_byte      out  8  round-key byte
//   busy         out  1  schedule in progress
//   ready        out  1  all round keys valid
//   err          out  1  one-cycle error pulse
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, round=0, rcon=8'h01. Key storage is not cleared.
//   FSM: IDLE -start-> LOAD -16th key byte-> FEED -16th byte sent-> WAIT -16th byte got-> NEXT
//        NEXT -> FEED while round<NUM_ROUNDS, else DONE. DONE -start-> LOAD.
//   LOAD: each key_valid byte -> store[0][idx]. busy=1. Non-consecutive bytes allowed.
//   FEED: 1st cycle ke_start=1. Next 16 cycles: ke_key_valid=1, bytes store[round][0..15].
//   WAIT: each ke_out_valid byte -> store[round+1][idx]. After 16 bytes, go to NEXT.
//   NEXT (1 cycle): round++, rcon <= {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 8'h00).
//     RCON sequence: 01,02,04,08,10,20,40,80,1b,36.
//   DONE: ready=1, busy=0. ready drops the cycle after a start is accepted.
//   Read port, active only when ready=1 and no stream is in progress. rk_req is sampled there.
//     Starting the next cycle, rk_valid=1 for exactly 16 cycles with store[rk_round][0..15].
//   rk_round>NUM_ROUNDS: err=1 for 1 cycle, no stream.
//   rk_req while not ready, or while streaming: ignored, no err.
//   start while busy: ignored. start in DONE during a read stream: deferred until the stream ends.
//   key_valid outside LOAD, and ke_out_valid outside WAIT: ignored. Bytes past the 16th are ignored.
//   Reset mid-operation: immediate return to IDLE, ready=0, streams aborted.
//   Latency per schedule: 16 (LOAD) + NUM_ROUNDS*(17 + expander latency + 1).
// CONFIGURATION
//   KEY_SCHED_TIMEOUT_EN defined:
//     WAIT has a cycle counter, cleared on each ke_out_valid.
//     Reaching TIMEOUT: err=1 for 1 cycle, state -> IDLE, ready=0.
//   KEY_SCHED_TIMEOUT_EN undefined: WAIT waits indefinitely. err is driven only by bad rk_round.
// STRUCTURE
//   Shared package aes_pkg:
//     AES_KEY_BYTES=16, AES_ROUNDS=10, RCON_INIT=8'h01;
//     function xtime(8b); state typedef (IDLE,LOAD,FEED,WAIT,NEXT,DONE).
//   Sub-module aes_rk_store: (NUM_ROUNDS+1)*KEY_BYTES x 8 register file.
//     One synchronous write port, one combinational read port (round,idx).
//   Controller holds the FSM, byte counter, round counter, rcon and read-stream counter.
// TESTING
//   Bench uses a golden byte-serial expander model with 3-cycle latency.
//   1. Key 2b7e151628aed2a6abf7158809cf4f3c, start. Response:
//      ready after full schedule; rk_round=1 streams a0fafe1788542cb123a339392a6c7605;
//      rk_round=10 streams d014f9a8c9ee2589e13f0cc8b6630ca6.
//   2. Monitor ke_rcon at each ke_start -> 01,02,04,08,10,20,40,80,1b,36.
//      Exactly 10 ke_start pulses.
//   3. rk_req with rk_round=11 while ready -> err pulse 1 cycle, rk_valid stays 0.
//      rk_req while busy -> ignored.
//   4. Assert rst_n low mid-WAIT of round 5 -> busy=0, ready=0, all outputs 0.
//      New start then completes correctly.
//   5. start pulses during LOAD/FEED -> ignored. Extra key bytes -> ignored.
//      Gapped key_valid (1 byte per 3 cycles) -> same round keys as test 1.
//   6. KEY_SCHED_TIMEOUT_EN, TIMEOUT=20, expander stalls after 7 bytes:
//      err after 20 idle cycles, state IDLE.
//      Without the macro: busy stays 1 indefinitely.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants, key-schedule state encoding and GF(2^8) doubling helper
package aes_pkg;
    localparam int AES_KEY_BYTES = 16;
    localparam int AES_ROUNDS = 10;
    localparam logic [7:0] RCON_INIT = 8'h01;
    typedef enum logic [2:0] {IDLE, LOAD, FEED, WAIT, NEXT, DONE} ks_state_t;
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction
endpackage

// File: rtl/aes_rk_store.sv
// aes_rk_store: round-key register file, one synchronous write port and one combinational read port
module aes_rk_store
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_ROUNDS,
    parameter int KEY_BYTES  = AES_KEY_BYTES
) (
    input  logic       clk,
    input  logic       we,
    input  logic [3:0] w_round,
    input  logic [3:0] w_idx,
    input  logic [7:0] w_data,
    input  logic [3:0] r_round,
    input  logic [3:0] r_idx,
    output logic [7:0] r_data
);
    localparam int DEPTH = (NUM_ROUNDS + 1) * KEY_BYTES;
    localparam int AW = $clog2(DEPTH);
    logic [7:0] mem [DEPTH];
    logic [AW-1:0] wa, ra;
    assign wa = AW'(w_round) * AW'(KEY_BYTES) + AW'(w_idx);
    assign ra = AW'(r_round) * AW'(KEY_BYTES) + AW'(r_idx);
    // out-of-range rounds read as zero so a bad rk_round never touches storage
    assign r_data = (int'(ra) < DEPTH) ? mem[ra] : 8'h00;
    always_ff @(posedge clk) begin
        if (we && int'(wa) < DEPTH) mem[wa] <= w_data;
    end
endmodule

// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: AES-128 key-schedule sequencer and round-key server; define KEY_SCHED_TIMEOUT_EN for the WAIT watchdog
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_ROUNDS,
    parameter int KEY_BYTES  = AES_KEY_BYTES,
    parameter int TIMEOUT    = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       key_valid,
    input  logic [7:0] key_byte,
    output logic       ke_start,
    output logic [7:0] ke_rcon,
    output logic       ke_key_valid,
    output logic [7:0] ke_key_byte,
    input  logic       ke_out_valid,
    input  logic [7:0] ke_out_byte,
    input  logic       rk_req,
    input  logic [3:0] rk_round,
    output logic       rk_valid,
    output logic [7:0] rk_byte,
    output logic       busy,
    output logic       ready,
    output logic       err
);
    localparam logic [4:0] KB = 5'(KEY_BYTES);
    localparam logic [4:0] LAST = 5'(KEY_BYTES - 1);
    ks_state_t state;
    logic [4:0] cnt;
    logic [3:0] round, rk_sel, rd_cnt, w_round, r_round, r_idx;
    logic [7:0] rcon, rd_data, w_data;
    logic start_pend, we;
    assign we = (state == LOAD && key_valid) || (state == WAIT && ke_out_valid);
    assign w_round = (state == WAIT) ? round + 4'd1 : round;
    assign w_data = (state == WAIT) ? ke_out_byte : key_byte;
    assign r_round = (state == DONE) ? (rk_valid ? rk_sel : rk_round) : round;
    assign r_idx = (state == DONE) ? (rk_valid ? rd_cnt + 4'd1 : 4'd0) : cnt[3:0];
    assign ke_rcon = (state == FEED || state == WAIT) ? rcon : 8'h00;
    aes_rk_store #(.NUM_ROUNDS(NUM_ROUNDS), .KEY_BYTES(KEY_BYTES)) u_store (
        .clk(clk), .we(we), .w_round(w_round), .w_idx(cnt[3:0]), .w_data(w_data),
        .r_round(r_round), .r_idx(r_idx), .r_data(rd_data)
    );
`ifdef KEY_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            round <= '0;
            rcon <= RCON_INIT;
            rk_sel <= '0;
            rd_cnt <= '0;
            start_pend <= 1'b0;
            ke_start <= 1'b0;
            ke_key_valid <= 1'b0;
            ke_key_byte <= 8'h00;
            rk_valid <= 1'b0;
            rk_byte <= 8'h00;
            busy <= 1'b0;
            ready <= 1'b0;
            err <= 1'b0;
`ifdef KEY_SCHED_TIMEOUT_EN
            wd <= '0;
`endif
        end else begin
            ke_start <= 1'b0;
            err <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state <= LOAD;
                    cnt <= '0;
                    round <= '0;
                    rcon <= RCON_INIT;
                    busy <= 1'b1;
                end
                LOAD: if (key_valid) begin
                    cnt <= (cnt == LAST) ? 5'd0 : cnt + 5'd1;
                    if (cnt == LAST) begin
                        state <= FEED;
                        ke_start <= 1'b1;
                    end
                end
                FEED: begin
                    // cnt 0 is the ke_start cycle; bytes leave one cycle behind their read
                    ke_key_valid <= cnt != KB;
                    ke_key_byte <= (cnt != KB) ? rd_data : 8'h00;
                    cnt <= (cnt == KB) ? 5'd0 : cnt + 5'd1;
                    if (cnt == KB) state <= WAIT;
`ifdef KEY_SCHED_TIMEOUT_EN
                    wd <= '0;
`endif
                end
                WAIT: begin
                    if (ke_out_valid) begin
                        cnt <= (cnt == LAST) ? 5'd0 : cnt + 5'd1;
                        if (cnt == LAST) state <= NEXT;
                    end
`ifdef KEY_SCHED_TIMEOUT_EN
                    wd <= ke_out_valid ? '0 : wd + 1'b1;
                    if (!ke_out_valid && wd == WD_W'(TIMEOUT - 1)) begin
                        state <= IDLE;
                        cnt <= '0;
                        err <= 1'b1;
                        busy <= 1'b0;
                        ready <= 1'b0;
                    end
`endif
                end
                NEXT: begin
                    round <= round + 4'd1;
                    rcon <= xtime(rcon);
                    state <= (round == 4'(NUM_ROUNDS - 1)) ? DONE : FEED;
                    ke_start <= round != 4'(NUM_ROUNDS - 1);
                    busy <= round != 4'(NUM_ROUNDS - 1);
                    ready <= round == 4'(NUM_ROUNDS - 1);
                end
                DONE: begin
                    if (rk_valid) begin
                        rd_cnt <= rd_cnt + 4'd1;
                        rk_valid <= rd_cnt != 4'(KEY_BYTES - 1);
                        rk_byte <= (rd_cnt != 4'(KEY_BYTES - 1)) ? rd_data : 8'h00;
                        if (start) start_pend <= 1'b1;
                    end else if (start || start_pend) begin
                        state <= LOAD;
                        cnt <= '0;
                        round <= '0;
                        rcon <= RCON_INIT;
                        busy <= 1'b1;
                        ready <= 1'b0;
                        start_pend <= 1'b0;
                    end else if (rk_req) begin
                        if (rk_round > 4'(NUM_ROUNDS)) err <= 1'b1;
                        else begin
                            rk_valid <= 1'b1;
                            rd_cnt <= '0;
                            rk_sel <= rk_round;
                            rk_byte <= rd_data;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
